alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_alu_exec.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec : multi-cycle integer execute unit
//
// Accepts one operation per request while idle, computes it and presents the
// result, condition flags and write-back controls for exactly one cycle (done).
// Single-cycle ops (ADD/SUB/AND/ORR/EOR/MOV/CMP and illegal opcodes) finish on
// the accepting edge; MUL iterates shift-add for 32 edges; LSL/LSR shift one
// bit per edge for source_2[4:0] edges.
//
// Ports
//   clk       in   rising-edge clock for all state
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only while idle
//   opcode    in   [3:0] operation select, captured with start
//   source_1  in   [WIDTH-1:0] first operand, captured with start
//   source_2  in   [WIDTH-1:0] second operand / shift amount, captured with start
//   dest_in   in   [3:0] destination register number, captured with start
//   busy      out  high whenever the FSM is not idle
//   done      out  one-cycle completion pulse
//   result    out  [WIDTH-1:0] operation result, held until the next done
//   dest_out  out  [3:0] captured destination register number
//   wr_en     out  register write strobe, only ever high together with done
//   flags     out  [3:0] {N,Z,C,V}, held until the next done
//   err       out  illegal-opcode indication, meaningful only with done
// -----------------------------------------------------------------------------
module alu_exec #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] source_1,
   input  logic [WIDTH-1:0] source_2,
   input  logic [3:0]       dest_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       dest_out,
   output logic             wr_en,
   output logic [3:0]       flags,
   output logic             err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] MUL   = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_ORR = 4'd3;
   localparam logic [3:0] OP_EOR = 4'd4;
   localparam logic [3:0] OP_MOV = 4'd5;
   localparam logic [3:0] OP_LSL = 4'd6;
   localparam logic [3:0] OP_LSR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_CMP = 4'd9;

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   // registered state and outputs
   logic [1:0]       state_r;
   logic             busy_r;
   logic             done_r;
   logic             wr_en_r;
   logic             err_r;
   logic [WIDTH-1:0] result_r;
   logic [3:0]       flags_r;
   logic [3:0]       dest_out_r;
   // iteration datapath: op_a holds multiplicand or shift value, op_b the
   // multiplier, acc the partial product, cnt the step counter
   logic [3:0]       opcode_r;
   logic [WIDTH-1:0] op_a_r;
   logic [WIDTH-1:0] op_b_r;
   logic [WIDTH-1:0] acc_r;
   logic [4:0]       cnt_r;

   // next-state values
   logic [1:0]       state_nxt_s;
   logic             busy_nxt_s;
   logic             done_nxt_s;
   logic             wr_en_nxt_s;
   logic             err_nxt_s;
   logic [WIDTH-1:0] result_nxt_s;
   logic [3:0]       flags_nxt_s;
   logic [3:0]       dest_out_nxt_s;
   logic [3:0]       opcode_nxt_s;
   logic [WIDTH-1:0] op_a_nxt_s;
   logic [WIDTH-1:0] op_b_nxt_s;
   logic [WIDTH-1:0] acc_nxt_s;
   logic [4:0]       cnt_nxt_s;

   // completion bundle, filled by whichever path finishes this edge
   logic             go_done_s;
   logic [WIDTH-1:0] fin_res_s;
   logic             fin_c_s;
   logic             fin_v_s;
   logic             fin_wr_s;
   logic             fin_err_s;

   // single-cycle arithmetic on the live operands
   logic [WIDTH:0]   add_s;
   logic [WIDTH:0]   sub_s;
   logic             add_v_s;
   logic             sub_v_s;
   // iterative step values
   logic [WIDTH-1:0] acc_step_s;
   logic [WIDTH-1:0] shift_step_s;
   logic             shift_out_s;

   assign busy     = busy_r;
   assign done     = done_r;
   assign wr_en    = wr_en_r;
   assign err      = err_r;
   assign result   = result_r;
   assign flags    = flags_r;
   assign dest_out = dest_out_r;

   // adder/subtracter and their overflow terms; sub_s[WIDTH] is NOT borrow
   always_comb begin
      add_s   = {1'b0, source_1} + {1'b0, source_2};
      sub_s   = {1'b0, source_1} + {1'b0, ~source_2} + {{WIDTH{1'b0}}, 1'b1};
      add_v_s = (source_1[WIDTH-1] == source_2[WIDTH-1]) &&
                (add_s[WIDTH-1] != source_1[WIDTH-1]);
      sub_v_s = (source_1[WIDTH-1] != source_2[WIDTH-1]) &&
                (sub_s[WIDTH-1] != source_1[WIDTH-1]);
   end

   // one shift-add step and one single-bit shift step
   always_comb begin
      acc_step_s = acc_r + (op_b_r[0] ? op_a_r : ZERO);
      if (opcode_r == OP_LSR) begin
         shift_step_s = {1'b0, op_a_r[WIDTH-1:1]};
         shift_out_s  = op_a_r[0];
      end else begin
         shift_step_s = {op_a_r[WIDTH-2:0], 1'b0};
         shift_out_s  = op_a_r[WIDTH-1];
      end
   end

   // FSM transition and output next-value logic
   always_comb begin
      state_nxt_s    = state_r;
      done_nxt_s     = 1'b0;
      wr_en_nxt_s    = 1'b0;
      err_nxt_s      = 1'b0;
      result_nxt_s   = result_r;
      flags_nxt_s    = flags_r;
      dest_out_nxt_s = dest_out_r;
      opcode_nxt_s   = opcode_r;
      op_a_nxt_s     = op_a_r;
      op_b_nxt_s     = op_b_r;
      acc_nxt_s      = acc_r;
      cnt_nxt_s      = cnt_r;
      go_done_s      = 1'b0;
      fin_res_s      = ZERO;
      fin_c_s        = 1'b0;
      fin_v_s        = 1'b0;
      fin_wr_s       = 1'b0;
      fin_err_s      = 1'b0;

      case (state_r)
         IDLE: begin
            if (start) begin
               opcode_nxt_s   = opcode;
               dest_out_nxt_s = dest_in;
               case (opcode)
                  OP_ADD: begin
                     go_done_s = 1'b1;
                     fin_res_s = add_s[WIDTH-1:0];
                     fin_c_s   = add_s[WIDTH];
                     fin_v_s   = add_v_s;
                     fin_wr_s  = 1'b1;
                  end
                  OP_SUB: begin
                     go_done_s = 1'b1;
                     fin_res_s = sub_s[WIDTH-1:0];
                     fin_c_s   = sub_s[WIDTH];
                     fin_v_s   = sub_v_s;
                     fin_wr_s  = 1'b1;
                  end
                  OP_CMP: begin
                     go_done_s = 1'b1;
                     fin_res_s = sub_s[WIDTH-1:0];
                     fin_c_s   = sub_s[WIDTH];
                     fin_v_s   = sub_v_s;
                     fin_wr_s  = 1'b0;
                  end
                  OP_AND: begin
                     go_done_s = 1'b1;
                     fin_res_s = source_1 & source_2;
                     fin_wr_s  = 1'b1;
                  end
                  OP_ORR: begin
                     go_done_s = 1'b1;
                     fin_res_s = source_1 | source_2;
                     fin_wr_s  = 1'b1;
                  end
                  OP_EOR: begin
                     go_done_s = 1'b1;
                     fin_res_s = source_1 ^ source_2;
                     fin_wr_s  = 1'b1;
                  end
                  OP_MOV: begin
                     go_done_s = 1'b1;
                     fin_res_s = source_2;
                     fin_wr_s  = 1'b1;
                  end
                  OP_LSL, OP_LSR: begin
                     // a zero amount completes at once with the operand intact
                     if (source_2[4:0] == 5'd0) begin
                        go_done_s = 1'b1;
                        fin_res_s = source_1;
                        fin_wr_s  = 1'b1;
                     end else begin
                        state_nxt_s = SHIFT;
                        op_a_nxt_s  = source_1;
                        cnt_nxt_s   = source_2[4:0];
                     end
                  end
                  OP_MUL: begin
                     state_nxt_s = MUL;
                     op_a_nxt_s  = source_1;
                     op_b_nxt_s  = source_2;
                     acc_nxt_s   = ZERO;
                     cnt_nxt_s   = 5'd0;
                  end
                  default: begin
                     go_done_s = 1'b1;
                     fin_err_s = 1'b1;
                  end
               endcase
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MUL: begin
            acc_nxt_s  = acc_step_s;
            op_a_nxt_s = {op_a_r[WIDTH-2:0], 1'b0};
            op_b_nxt_s = {1'b0, op_b_r[WIDTH-1:1]};
            cnt_nxt_s  = cnt_r + 5'd1;
            // the 32nd step lands in the result register directly
            if (cnt_r == 5'd31) begin
               go_done_s = 1'b1;
               fin_res_s = acc_step_s;
               fin_wr_s  = 1'b1;
            end else begin
               go_done_s = 1'b0;
            end
         end
         SHIFT: begin
            op_a_nxt_s = shift_step_s;
            cnt_nxt_s  = cnt_r - 5'd1;
            if (cnt_r == 5'd1) begin
               go_done_s = 1'b1;
               fin_res_s = shift_step_s;
               fin_c_s   = shift_out_s;
               fin_wr_s  = 1'b1;
            end else begin
               go_done_s = 1'b0;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase

      if (go_done_s) begin
         state_nxt_s  = DONE;
         done_nxt_s   = 1'b1;
         wr_en_nxt_s  = fin_wr_s;
         err_nxt_s    = fin_err_s;
         result_nxt_s = fin_res_s;
         if (fin_err_s) begin
            flags_nxt_s = 4'd0;
         end else begin
            flags_nxt_s = {fin_res_s[WIDTH-1], (fin_res_s == ZERO), fin_c_s, fin_v_s};
         end
      end else begin
         done_nxt_s = 1'b0;
      end

      busy_nxt_s = (state_nxt_s != IDLE);
   end

   // state and output registers; reset clears everything, aborting any op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         wr_en_r    <= 1'b0;
         err_r      <= 1'b0;
         result_r   <= ZERO;
         flags_r    <= 4'd0;
         dest_out_r <= 4'd0;
         opcode_r   <= 4'd0;
         op_a_r     <= ZERO;
         op_b_r     <= ZERO;
         acc_r      <= ZERO;
         cnt_r      <= 5'd0;
      end else begin
         state_r    <= state_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         wr_en_r    <= wr_en_nxt_s;
         err_r      <= err_nxt_s;
         result_r   <= result_nxt_s;
         flags_r    <= flags_nxt_s;
         dest_out_r <= dest_out_nxt_s;
         opcode_r   <= opcode_nxt_s;
         op_a_r     <= op_a_nxt_s;
         op_b_r     <= op_b_nxt_s;
         acc_r      <= acc_nxt_s;
         cnt_r      <= cnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec : directed self-checking bench for alu_exec
// -----------------------------------------------------------------------------
module tb_alu_exec;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  opcode;
   logic [31:0] source_1;
   logic [31:0] source_2;
   logic [3:0]  dest_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [3:0]  dest_out;
   logic        wr_en;
   logic [3:0]  flags;
   logic        err;

   int errors = 0;
   int checks = 0;
   int cyc;
   int bcyc;
   int done_seen;

   alu_exec #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .opcode   (opcode),
      .source_1 (source_1),
      .source_2 (source_2),
      .dest_in  (dest_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .dest_out (dest_out),
      .wr_en    (wr_en),
      .flags    (flags),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with the FSM idle; returns at the falling edge
   // where done is seen. cyc counts falling edges after the accepting edge.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d, input bit inject,
                         output int c, output int bc);
      opcode = op; source_1 = a; source_2 = b; dest_in = d; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      c = 0; bc = 0;
      while (c < 100) begin
         @(negedge clk);
         c++;
         if (busy) bc++;
         if (done) break;
         if (inject && (c == 5 || c == 20)) begin
            start = 1'b1; opcode = 4'd0; source_1 = 32'h1111_1111;
            source_2 = 32'h2222_2222; dest_in = 4'd9;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("done_within_budget", {31'd0, done}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; opcode = 4'd0;
      source_1 = 32'd0; source_2 = 32'd0; dest_in = 4'd0;

      // reset state, before any clock edge
      #3;
      chk("rst_ctl", {28'd0, busy, done, wr_en, err}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags_dest", {24'd0, flags, dest_out}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD wrap to zero, accepted at the first edge after reset release
      run_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3, 1'b0, cyc, bcyc);
      chk("add_latency", 32'(cyc), 32'd1);
      chk("add_result", result, 32'h0000_0000);
      chk("add_flags", {28'd0, flags}, 32'h6);
      chk("add_wr_dest_err", {26'd0, wr_en, err, dest_out}, {26'd0, 1'b1, 1'b0, 4'd3});
      @(negedge clk);
      chk("add_back_idle", {29'd0, busy, done, wr_en}, 32'd0);
      chk("add_result_held", result, 32'h0000_0000);

      // signed overflow on ADD
      run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd1, 1'b0, cyc, bcyc);
      chk("addv_result", result, 32'h8000_0000);
      chk("addv_flags", {28'd0, flags}, 32'h9);
      @(negedge clk);

      // SUB with overflow and borrow
      run_op(4'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd2, 1'b0, cyc, bcyc);
      chk("sub_result", result, 32'h8000_0000);
      chk("sub_flags", {28'd0, flags}, 32'h9);
      @(negedge clk);

      // CMP equal: flags only, no write
      run_op(4'd9, 32'd5, 32'd5, 4'd4, 1'b0, cyc, bcyc);
      chk("cmp_flags", {28'd0, flags}, 32'h6);
      chk("cmp_wr_err", {30'd0, wr_en, err}, 32'd0);
      @(negedge clk);

      // logical ops and MOV
      run_op(4'd2, 32'hF0F0_FFFF, 32'h0FF0_00F0, 4'd5, 1'b0, cyc, bcyc);
      chk("and_result", result, 32'h00F0_00F0);
      chk("and_flags", {28'd0, flags}, 32'h0);
      @(negedge clk);
      run_op(4'd3, 32'h8000_0000, 32'h0000_0001, 4'd6, 1'b0, cyc, bcyc);
      chk("orr_result", result, 32'h8000_0001);
      chk("orr_flags", {28'd0, flags}, 32'h8);
      @(negedge clk);
      run_op(4'd4, 32'hFFFF_0000, 32'hFFFF_FFFF, 4'd7, 1'b0, cyc, bcyc);
      chk("eor_result", result, 32'h0000_FFFF);
      @(negedge clk);
      run_op(4'd5, 32'h1234_5678, 32'h0000_0000, 4'd8, 1'b0, cyc, bcyc);
      chk("mov_result", result, 32'h0000_0000);
      chk("mov_flags", {28'd0, flags}, 32'h4);
      chk("mov_wr", {31'd0, wr_en}, 32'd1);
      @(negedge clk);

      // LSR by 1: one shift edge, C from bit 0
      run_op(4'd7, 32'h8000_0001, 32'h0000_0001, 4'd1, 1'b0, cyc, bcyc);
      chk("lsr1_latency", 32'(cyc), 32'd2);
      chk("lsr1_result", result, 32'h4000_0000);
      chk("lsr1_flags", {28'd0, flags}, 32'h2);
      @(negedge clk);

      // LSL by 0 (amount field zero, upper bits set): immediate, C cleared
      run_op(4'd6, 32'h1234_5678, 32'h0000_0020, 4'd2, 1'b0, cyc, bcyc);
      chk("lsl0_latency", 32'(cyc), 32'd1);
      chk("lsl0_result", result, 32'h1234_5678);
      chk("lsl0_flags", {28'd0, flags}, 32'h0);
      @(negedge clk);

      // LSL by 2 shifting everything out
      run_op(4'd6, 32'hC000_0000, 32'h0000_0002, 4'd3, 1'b0, cyc, bcyc);
      chk("lsl2_latency", 32'(cyc), 32'd3);
      chk("lsl2_result", result, 32'h0000_0000);
      chk("lsl2_flags", {28'd0, flags}, 32'h6);
      @(negedge clk);

      // LSR by maximum amount 31
      run_op(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4, 1'b0, cyc, bcyc);
      chk("lsr31_latency", 32'(cyc), 32'd32);
      chk("lsr31_result", result, 32'h0000_0001);
      chk("lsr31_flags", {28'd0, flags}, 32'h0);
      @(negedge clk);

      // MUL with start pulses injected while busy
      run_op(4'd8, 32'h0001_0000, 32'h0001_0001, 4'd7, 1'b1, cyc, bcyc);
      chk("mul_latency", 32'(cyc), 32'd33);
      chk("mul_busy_cycles", 32'(bcyc), 32'd33);
      chk("mul_result", result, 32'h0001_0000);
      chk("mul_flags", {28'd0, flags}, 32'h0);
      chk("mul_dest_wr", {27'd0, wr_en, dest_out}, {27'd0, 1'b1, 4'd7});
      @(negedge clk);
      chk("mul_back_idle", {30'd0, busy, done}, 32'd0);

      // illegal opcode
      run_op(4'hF, 32'h0000_1234, 32'h0000_5678, 4'd2, 1'b0, cyc, bcyc);
      chk("ill_latency", 32'(cyc), 32'd1);
      chk("ill_err_wr", {30'd0, err, wr_en}, 32'h2);
      chk("ill_result", result, 32'h0000_0000);
      chk("ill_flags", {28'd0, flags}, 32'h0);
      @(negedge clk);
      chk("ill_err_cleared", {31'd0, err}, 32'd0);

      // MUL aborted by reset at cycle 10
      @(negedge clk);
      opcode = 4'd8; source_1 = 32'd3; source_2 = 32'd4; dest_in = 4'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ctl", {28'd0, busy, done, wr_en, err}, 32'd0);
      chk("abort_result_dest", {result[27:0], dest_out}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(4'd0, 32'd2, 32'd3, 4'd4, 1'b0, cyc, bcyc);
      chk("post_rst_latency", 32'(cyc), 32'd1);
      chk("post_rst_result", result, 32'd5);
      chk("post_rst_dest", {28'd0, dest_out}, 32'd4);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      chk("no_stray_done", 32'(done_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
